// File: rtl/out_writer.sv
`default_nettype none
// ============================================================================
//  Module      : out_writer
//  Description : Collects 8-bit PE result bytes, packs them little-endian
//                into 32-bit words and writes each word to consecutive
//                output-memory addresses, with a done pulse at burst end.
//  Revision    : 1.0 - initial release
// ============================================================================
module out_writer #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [8:0]       base_addr,
    input  logic [CNT_W-1:0] res_cnt,
    input  logic             res_valid,
    input  logic [7:0]       res_data,
    output logic             res_ready,
    output logic             wr_en,
    output logic [8:0]       wr_addr,
    output logic [31:0]      wr_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_FIN     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    state_t             r_state;
    logic [8:0]         r_addr;
    logic [CNT_W-1:0]   r_remaining;
    logic [1:0]         r_slot;
    logic [31:0]        r_pack;

    logic [31:0]        w_pack_merged;
    logic               w_xfer;
    logic               w_word_end;

    // Pack register with the incoming byte dropped into the current slot,
    // plus the handshake and end-of-word decode for this cycle.
    always_comb begin
        w_pack_merged                        = r_pack;
        w_pack_merged[{r_slot, 3'b000} +: 8] = res_data;
        w_xfer     = (r_state == S_COLLECT) && res_valid && res_ready;
        w_word_end = (r_slot == 2'd3) || (r_remaining == c_one);
    end

    // Burst FSM; every output is registered so it changes only on clk or rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_slot      <= '0;
            r_pack      <= '0;
            res_ready   <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= res_cnt;
                        r_slot      <= '0;
                        r_pack      <= '0;
                        busy        <= 1'b1;
                        if (res_cnt != '0) begin
                            r_state   <= S_COLLECT;
                            res_ready <= 1'b1;
                        end else begin
                            // Empty burst: nothing to write, just signal completion.
                            r_state <= S_FIN;
                            done    <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (w_xfer) begin
                        r_pack      <= w_pack_merged;
                        r_slot      <= r_slot + 2'd1;
                        r_remaining <= r_remaining - c_one;
                        if (w_word_end) begin
                            // Word complete (or last partial word): present it
                            // for exactly one cycle; unfilled bytes are still 0.
                            r_state   <= S_WRITE;
                            res_ready <= 1'b0;
                            wr_en     <= 1'b1;
                            wr_addr   <= r_addr;
                            wr_data   <= w_pack_merged;
                        end
                    end
                end

                S_WRITE: begin
                    wr_en  <= 1'b0;
                    r_slot <= '0;
                    r_pack <= '0;
                    r_addr <= r_addr + 9'd1;
                    if (r_remaining != '0) begin
                        r_state   <= S_COLLECT;
                        res_ready <= 1'b1;
                    end else begin
                        r_state <= S_FIN;
                        done    <= 1'b1;
                    end
                end

                S_FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state   <= S_IDLE;
                    res_ready <= 1'b0;
                    wr_en     <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_out_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_writer
//  Description : Self-checking bench for out_writer: table of bursts with a
//                scoreboard of expected writes, plus reset-mid-burst sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_out_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  base_addr = '0;
    logic [9:0]  res_cnt = '0;
    logic        res_valid = 1'b0;
    logic [7:0]  res_data = '0;
    logic        res_ready;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    out_writer #(.CNT_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .res_cnt   (res_cnt),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [8:0] base;
        int         cnt;
        logic [7:0] first;
        bit         rnd;
        int         exp_writes;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs[6];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int wr_seen = 0;
    int done_seen = 0;
    int done_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor / scoreboard pop, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_seen++;
            check("res_ready_in_write", {31'd0, res_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", {23'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {23'd0, wr_addr}, {23'd0, mon_e.addr});
                check("wr_data", wr_data, mon_e.data);
            end
        end
        if (done) begin
            done_seen++;
            done_cyc = cyc;
        end
    end

    task automatic run_burst(input logic [8:0] base, input int cnt, input logic [7:0] first,
                             input bit rnd, input int exp_writes);
        int         nw, sent, guard, w0, d0, start_cyc;
        bit         hs, pulsed;
        logic [31:0] word;
        logic [8:0]  last_a;
        wr_t         e;
        nw = (cnt + 3) / 4;
        word = '0;
        last_a = '0;
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int b = 0; b < 4; b++)
                if (w * 4 + b < cnt) word[8*b +: 8] = first + 8'(w * 4 + b);
            e.addr = base + 9'(w);
            e.data = word;
            last_a = e.addr;
            exp_q.push_back(e);
        end
        w0 = wr_seen;
        d0 = done_seen;
        pulsed = 1'b0;
        start = 1'b1; base_addr = base; res_cnt = 10'(cnt);
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0; base_addr = '0; res_cnt = '0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        sent = 0;
        guard = 0;
        while (sent < cnt && guard < 500) begin
            res_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            res_data = first + 8'(sent);
            if (rnd && sent == 2 && !pulsed) begin
                start = 1'b1; base_addr = 9'h0AA; res_cnt = 10'd3;
                pulsed = 1'b1;
            end
            hs = res_valid && res_ready;
            @(posedge clk); #1;
            start = 1'b0; base_addr = '0; res_cnt = '0;
            if (hs) sent++;
            guard++;
        end
        res_valid = 1'b0;
        check("bytes_sent", sent, cnt);
        guard = 0;
        while (done_seen == d0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("write_count", wr_seen - w0, exp_writes);
        check("done_count", done_seen - d0, 1);
        check("queue_empty", exp_q.size(), 0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        if (!rnd) check("done_latency", done_cyc - start_cyc, cnt + nw);
        if (nw > 0) begin
            check("wr_addr_hold", {23'd0, wr_addr}, {23'd0, last_a});
            check("wr_data_hold", wr_data, word);
        end
    endtask

    initial begin
        int w0;
        vecs[0] = '{base: 9'h010, cnt: 8,  first: 8'h01, rnd: 1'b0, exp_writes: 2};
        vecs[1] = '{base: 9'h020, cnt: 6,  first: 8'hA1, rnd: 1'b0, exp_writes: 2};
        vecs[2] = '{base: 9'h030, cnt: 0,  first: 8'h00, rnd: 1'b0, exp_writes: 0};
        vecs[3] = '{base: 9'h1FF, cnt: 5,  first: 8'h10, rnd: 1'b0, exp_writes: 2};
        vecs[4] = '{base: 9'h040, cnt: 12, first: 8'h30, rnd: 1'b1, exp_writes: 3};
        vecs[5] = '{base: 9'h100, cnt: 1,  first: 8'hEE, rnd: 1'b0, exp_writes: 1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_res_ready", {31'd0, res_ready}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {23'd0, wr_addr}, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_burst(vecs[i].base, vecs[i].cnt, vecs[i].first, vecs[i].rnd, vecs[i].exp_writes);

        // Reset in the middle of a burst after two of four bytes.
        w0 = wr_seen;
        start = 1'b1; base_addr = 9'h050; res_cnt = 10'd4;
        @(posedge clk); #1;
        start = 1'b0; base_addr = '0; res_cnt = '0;
        res_valid = 1'b1; res_data = 8'h55;
        @(posedge clk); #1;
        res_data = 8'h66;
        @(posedge clk); #1;
        res_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_res_ready", {31'd0, res_ready}, 32'd0);
        check("arst_wr_en", {31'd0, wr_en}, 32'd0);
        check("arst_wr_addr", {23'd0, wr_addr}, 32'd0);
        check("arst_wr_data", wr_data, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("no_write_after_abort", wr_seen - w0, 0);
        check("idle_after_abort", {31'd0, busy}, 32'd0);
        run_burst(9'h060, 4, 8'hC0, 1'b0, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/out_writer.md
OUT_WRITER -- requirements
Module: out_writer

Interface
REQ-001 SHALL have parameter: CNT_W, default 10, width of result-count input.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin a write burst.
REQ-005 SHALL have port: base_addr  input  9  first output-memory word address, sampled on accepted start.
REQ-006 SHALL have port: res_cnt  input  CNT_W  number of 8-bit results to write, sampled on accepted start.
REQ-007 SHALL have port: res_valid  input  1  PE result byte available.
REQ-008 SHALL have port: res_data  input  8  PE result byte.
REQ-009 SHALL have port: res_ready  output  1  writer accepts res_data this cycle.
REQ-010 SHALL have port: wr_en  output  1  output-memory write strobe.
REQ-011 SHALL have port: wr_addr  output  9  output-memory word address.
REQ-012 SHALL have port: wr_data  output  32  packed result word.
REQ-013 SHALL have port: busy  output  1  burst in progress.
REQ-014 SHALL have port: done  output  1  one-cycle pulse at burst end.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, WRITE, FIN.
REQ-016 IDLE: start=1 and res_cnt!=0 -> COLLECT next cycle; start=1 and res_cnt==0 -> FIN; start ignored in all other states.
REQ-017 On accepted start SHALL latch addr=base_addr, remaining=res_cnt, byte slot=0, pack register=0.
REQ-018 COLLECT: res_ready=1; a byte transfers only when res_valid and res_ready both 1 on a rising edge.
REQ-019 Transferred byte SHALL be stored at pack bits [8*slot+7:8*slot] (slot 0 = bits 7:0); slot increments by 1, remaining decrements by 1.
REQ-020 COLLECT -> WRITE on the edge transferring the 4th byte of a word (slot 3) or the last byte (remaining becomes 0).
REQ-021 WRITE: res_ready=0, wr_en=1 for exactly one cycle, wr_addr=addr, wr_data=pack register; unfilled bytes of a partial last word SHALL be 0.
REQ-022 Leaving WRITE SHALL clear slot and pack register and set addr=addr+1 modulo 512 (wraps 511->0); next state COLLECT if remaining!=0 else FIN.
REQ-023 FIN: done=1 for one cycle, then IDLE.
REQ-024 busy SHALL be 1 in COLLECT, WRITE, FIN and 0 in IDLE.
REQ-025 res_ready, wr_en, done SHALL be 0 outside their stated states; wr_addr/wr_data SHALL hold last values when wr_en=0.
REQ-026 res_valid low in COLLECT SHALL stall without state change; no timeout.
REQ-027 Latency: with res_valid held 1, a full word SHALL be written 5 cycles after its first byte enters COLLECT (4 transfer + 1 write); throughput one word per 5 cycles.
REQ-028 Number of writes per burst SHALL equal ceil(res_cnt/4); res_cnt counted modulo 2^CNT_W, no overflow detection.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, and res_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, internal counters and pack register 0.
REQ-030 rst asserted mid-burst SHALL abandon the burst with no further write; partially packed bytes discarded; after release, new start required.

Verification
REQ-031 Full words: base_addr=0x010, res_cnt=8, bytes 0x01..0x08 continuous -> writes 0x04030201@0x010, 0x08070605@0x011, then done pulse one cycle later.
REQ-032 Partial word: base_addr=0x020, res_cnt=6, bytes 0xA1..0xA6 -> 0xA4A3A2A1@0x020, 0x0000A6A5@0x021, done once.
REQ-033 Zero count and wrap: res_cnt=0 -> no wr_en, done one cycle after start; base_addr=0x1FF, res_cnt=5 -> writes at 0x1FF then 0x000.
REQ-034 Backpressure: res_valid toggled randomly, res_cnt=12 -> exactly 3 writes with correct order; start pulses during busy ignored; res_ready=0 in every WRITE cycle.
REQ-035 Reset mid-burst: rst asserted after 2 of 4 bytes -> all outputs 0 asynchronously, no write; new burst res_cnt=4 after release writes correct word at its base_addr.
